// File: rtl/stage_if.sv
// Instruction-fetch stage: PC ownership, single-outstanding imem requests and the IF/ID register.
// Optional IF_PERF_CNT_EN macro adds fetch/drop performance counters.
module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic [31:0] buf_q;
    logic [31:0] pc_d_s;
    logic [31:0] req_pc_d_s;
    logic [31:0] buf_d_s;
    logic [31:0] inst_d_s;
    logic [31:0] ifpc_d_s;
    logic        valid_d_s;
    logic        load_s;
    logic [31:0] load_inst_s;
    logic        drop_s;
    logic        outstanding_s;

    // Request outputs come straight from the state and PC registers.
    always_comb begin
        imem_req  = (state_r == REQ);
        imem_addr = pc_q;
    end

    // Next-state and next-register computation; redirect overrides everything else.
    always_comb begin
        next_state_s  = state_r;
        pc_d_s        = pc_q;
        req_pc_d_s    = req_pc_q;
        buf_d_s       = buf_q;
        inst_d_s      = if_inst;
        ifpc_d_s      = if_pc;
        valid_d_s     = if_valid;
        load_s        = 1'b0;
        load_inst_s   = buf_q;
        drop_s        = 1'b0;
        outstanding_s = 1'b0;
        if (redirect) begin
            // A pending response must be swallowed in DROP before the target is fetched.
            outstanding_s = ((state_r == WAIT) && !imem_rvalid) ||
                            ((state_r == REQ)  && imem_gnt)     ||
                            ((state_r == DROP) && !imem_rvalid);
            next_state_s  = outstanding_s ? DROP : REQ;
            pc_d_s        = align_pc(redirect_pc);
            buf_d_s       = NOP_INST;
            inst_d_s      = NOP_INST;
            ifpc_d_s      = align_pc(redirect_pc);
            valid_d_s     = 1'b0;
            drop_s        = (state_r == DROP) && imem_rvalid;
        end else begin
            case (state_r)
                IDLE: next_state_s = REQ;
                REQ: begin
                    if (imem_gnt) begin
                        next_state_s = WAIT;
                        req_pc_d_s   = pc_q;
                    end else begin
                        next_state_s = REQ;
                    end
                end
                WAIT: begin
                    if (imem_rvalid && !stall) begin
                        load_s       = 1'b1;
                        load_inst_s  = imem_rdata;
                        next_state_s = REQ;
                    end else if (imem_rvalid) begin
                        buf_d_s      = imem_rdata;
                        next_state_s = HOLD;
                    end else begin
                        next_state_s = WAIT;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        load_s       = 1'b1;
                        load_inst_s  = buf_q;
                        next_state_s = REQ;
                    end else begin
                        next_state_s = HOLD;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        drop_s       = 1'b1;
                        next_state_s = REQ;
                    end else begin
                        next_state_s = DROP;
                    end
                end
                default: next_state_s = IDLE;
            endcase
            // Stall without a new instruction keeps IF/ID as is; decode inserts its own bubble.
            if (load_s) begin
                inst_d_s  = load_inst_s;
                ifpc_d_s  = req_pc_q;
                valid_d_s = 1'b1;
                pc_d_s    = req_pc_q + 32'd4;
            end else if (!stall) begin
                inst_d_s  = NOP_INST;
                ifpc_d_s  = pc_q;
                valid_d_s = 1'b0;
            end else begin
                inst_d_s  = if_inst;
                ifpc_d_s  = if_pc;
                valid_d_s = if_valid;
            end
        end
    end

    // State, PC, skid buffer and IF/ID registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            buf_q    <= NOP_INST;
            if_inst  <= NOP_INST;
            if_pc    <= RESET_PC;
            if_valid <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            pc_q     <= pc_d_s;
            req_pc_q <= req_pc_d_s;
            buf_q    <= buf_d_s;
            if_inst  <= inst_d_s;
            if_pc    <= ifpc_d_s;
            if_valid <= valid_d_s;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Performance counters: valid IF/ID loads and responses discarded in DROP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetch_cnt <= 32'd0;
            perf_drop_cnt  <= 32'd0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + {31'd0, (load_s && !redirect)};
            perf_drop_cnt  <= perf_drop_cnt + {31'd0, drop_s};
        end
    end
`endif

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: scoreboard of expected IF/ID loads plus per-cycle handshake checks.
module tb_stage_if;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    stage_if dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_inst(if_inst), .if_pc(if_pc), .if_valid(if_valid)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle with the given memory/hazard inputs; returns at the following negedge.
    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic st, input logic re, input logic [31:0] rp);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        stall = st; redirect = re; redirect_pc = rp;
        @(posedge clk);
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    endtask

    // Monitor: every newly presented valid IF/ID word is matched against the scoreboard.
    logic        prev_v = 1'b0;
    logic [31:0] prev_pc = 32'd0;
    logic [31:0] prev_inst = 32'd0;
    always @(negedge clk) begin
        if (reset && if_valid && !(prev_v && prev_pc == if_pc && prev_inst == if_inst)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ifid_unexpected: got pc=%h inst=%h expected none", if_pc, if_inst);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({if_pc, if_inst} !== e) begin
                    errors++;
                    $display("FAIL ifid_load: got pc=%h inst=%h expected pc=%h inst=%h",
                             if_pc, if_inst, e[63:32], e[31:0]);
                end
            end
        end
        prev_v = if_valid; prev_pc = if_pc; prev_inst = if_inst;
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_inst", if_inst, NOP);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);

        // Reset release and zero-wait fetches of 0 and 4.
        reset = 1'b1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        exp_q.push_back({32'd0, 32'h0000_0100});
        drive(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0);
        chk("valid_after_load", {31'd0, if_valid}, 32'd1);
        chk("addr_4", imem_addr, 32'd4);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        exp_q.push_back({32'd4, 32'h0000_0104});
        drive(1'b0, 1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'd0);
        chk("addr_8", imem_addr, 32'd8);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        // Stall as the response for PC 8 returns: data parks in HOLD.
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_valid", {31'd0, if_valid}, 32'd0);
        chk("hold_pc", if_pc, 32'd8);
        chk("hold_inst", if_inst, NOP);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("hold2_req", {31'd0, imem_req}, 32'd0);
        exp_q.push_back({32'd8, 32'hDEAD_BEEF});
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("after_hold_addr", imem_addr, 32'd12);
        chk("after_hold_req", {31'd0, imem_req}, 32'd1);

        // Redirect while the fetch of 12 is outstanding; the late response is dropped.
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0203);
        chk("redir_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_pc", if_pc, 32'h0000_0200);
        chk("redir_inst", if_inst, NOP);
        chk("drop_req", {31'd0, imem_req}, 32'd0);
        drive(1'b0, 1'b1, 32'hBAD0_0001, 1'b0, 1'b0, 32'd0);
        chk("target_addr", imem_addr, 32'h0000_0200);
        chk("target_req", {31'd0, imem_req}, 32'd1);
        chk("drop_valid", {31'd0, if_valid}, 32'd0);

        // Redirect and stall together: redirect wins, nothing outstanding.
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0400);
        chk("rs_valid", {31'd0, if_valid}, 32'd0);
        chk("rs_pc", if_pc, 32'h0000_0400);
        chk("rs_addr", imem_addr, 32'h0000_0400);
        chk("rs_req", {31'd0, imem_req}, 32'd1);

        // Grant withheld for five cycles.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
            chk("nogrant_req", {31'd0, imem_req}, 32'd1);
            chk("nogrant_addr", imem_addr, 32'h0000_0400);
            chk("nogrant_valid", {31'd0, if_valid}, 32'd0);
        end
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        exp_q.push_back({32'h0000_0400, 32'h0000_0500});
        drive(1'b0, 1'b1, 32'h0000_0500, 1'b0, 1'b0, 32'd0);
        chk("addr_404", imem_addr, 32'h0000_0404);

        // Redirect to the top word coincident with a grant, then wrap to 0.
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        chk("wrap_drop_req", {31'd0, imem_req}, 32'd0);
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        drive(1'b0, 1'b1, 32'hBAD0_0002, 1'b0, 1'b0, 32'd0);
        chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        exp_q.push_back({32'hFFFF_FFFC, 32'h1234_5678});
        drive(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
        chk("wrap_addr_zero", imem_addr, 32'd0);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt, 32'd5);
        chk("perf_drop", perf_drop_cnt, 32'd2);
`endif

        // Reset with a request outstanding; a response landing in IDLE is ignored.
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        reset = 1'b1;
        drive(1'b0, 1'b1, 32'hBAD0_0003, 1'b0, 1'b0, 32'd0);
        chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("mid_rst_addr", imem_addr, 32'd0);
        chk("mid_rst_req", {31'd0, imem_req}, 32'd1);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch_rst", perf_fetch_cnt, 32'd0);
        chk("perf_drop_rst", perf_drop_cnt, 32'd0);
`endif
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        exp_q.push_back({32'd0, 32'h0000_0077});
        drive(1'b0, 1'b1, 32'h0000_0077, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
